// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmitter and matching receiver.
// Optional parity is selected in the transmitter with SERIAL_FRAME_TX_PARITY_EN.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width that never collapses to zero bits (a divide-by-1 still needs a register).
    function automatic int unsigned min1_clog2(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit cycle timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is high so every bit period starts from a fresh count.
module frame_bit_timer
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = min1_clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == TERM)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == TERM);

endmodule

// File: rtl/serial_frame_tx.sv
// Idle-high LSB-first serializer: start, DATA_W data bits, optional even parity, stop.
// Define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dataout,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    tx_state_t         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CW-1:0]     bit_cnt_q;
    logic              dataout_q;
    logic              busy_q;
    logic              bit_done;
    logic              accept;
    logic              timer_clear;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              parity_q;
`endif

    assign tx_ready    = rst && en && (state_q == IDLE);
    assign accept      = tx_valid && tx_ready;
    // Every state change happens on a terminal count, so only IDLE needs to pin the timer.
    assign timer_clear = (state_q == IDLE);

    frame_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    // dataout is loaded with the level of the state being entered, so the line is registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dataout_q <= LINE_IDLE;
            busy_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= tx_data;
                        bit_cnt_q <= '0;
                        state_q   <= START;
                        dataout_q <= START_LEVEL;
                        busy_q    <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        parity_q  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q   <= DATA;
                        dataout_q <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            state_q   <= PARITY;
                            dataout_q <= parity_q;
`else
                            state_q   <= STOP;
                            dataout_q <= STOP_LEVEL;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                            dataout_q <= shift_q[1];
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state_q   <= STOP;
                        dataout_q <= STOP_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state_q   <= IDLE;
                        dataout_q <= LINE_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    dataout_q <= LINE_IDLE;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dataout = dataout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: directed frame table, corner sequences,
// and randomized traffic against a queue-of-line-levels reference model.
module tb_serial_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 2 + DW + PB;
    localparam int F     = NBITS * CPB;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          en       = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_ready;
    logic          dataout;
    logic          busy;

    always #5 clk = ~clk;

    serial_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .dataout (dataout),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: an accepted word expands into the full list of per-cycle line levels.
    logic m_busy   = 1'b0;
    logic m_line   = 1'b1;
    logic m_accept = 1'b0;
    bit   m_q[$];

    typedef struct {
        logic [7:0] data;
        int         stall_at;
        int         stall_len;
        logic [9:0] exp_frame;  // bit0 = start, bits 8:1 = data LSB first, bit9 = stop
        logic       exp_par;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        m_accept = 1'b0;
        if (!rst) begin
            m_busy = 1'b0;
            m_line = 1'b1;
            m_q.delete();
        end else if (en) begin
            if (m_busy) begin
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_line = 1'b1;
                end else begin
                    m_line = m_q.pop_front();
                end
            end else if (tx_valid) begin
                m_q.delete();
                repeat (CPB) m_q.push_back(1'b0);
                for (int i = 0; i < DW; i++) repeat (CPB) m_q.push_back(tx_data[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
                repeat (CPB) m_q.push_back(^tx_data);
`endif
                repeat (CPB) m_q.push_back(1'b1);
                m_line   = m_q.pop_front();
                m_busy   = 1'b1;
                m_accept = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are compared mid-cycle on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("dataout", dataout, m_line);
        chk("busy", busy, m_busy);
        chk("tx_ready", tx_ready, rst && en && !m_busy);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_busy && guard < 4 * F) begin
            cycle();
            guard++;
        end
        chk("idle_timeout", m_busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [10:0] got;
        int          busy_cnt;
        logic        frozen;
        got      = '0;
        busy_cnt = 0;
        wait_idle();
        tx_data  = v.data;
        tx_valid = 1'b1;
        cycle();
        tx_valid = 1'b0;
        for (int k = 0; k < F; k++) begin
            if (busy) busy_cnt++;
            if (k % CPB == CPB / 2) got[k / CPB] = dataout;
            if (k == v.stall_at) begin
                frozen = dataout;
                en = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    cycle();
                    chk("stall_hold", dataout, frozen);
                    if (busy) busy_cnt++;
                end
                en = 1'b1;
            end
            cycle();
        end
        chk("busy_after_frame", busy, 1'b0);
        chk("ready_after_frame", tx_ready, 1'b1);
        chk("busy_length", busy_cnt, F + v.stall_len);
        chk("frame_bits", {got[NBITS-1], got[DW:0]}, v.exp_frame);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        chk("parity_bit", got[DW+1], v.exp_par);
`endif
        $display("frame data=%02h stall=%0d busy_cycles=%0d bits=%b", v.data, v.stall_len, busy_cnt, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, t1, acc, guard;
        logic prev_busy;

        vecs[0] = '{8'hA5, -1, 0, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h07, -1, 0, 10'b1000001110, 1'b1};
        vecs[2] = '{8'h5A, 17, 7, 10'b1010110100, 1'b0};
        vecs[3] = '{8'h81, -1, 0, 10'b1100000010, 1'b0};

        // Reset held with a pending word: nothing may be accepted or driven.
        rst = 1'b0; en = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_dataout", dataout, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_ready", tx_ready, 1'b0);
        end
        tx_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("ready_after_rst", tx_ready, 1'b1);
        $display("reset sequence done");

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Back-to-back words with tx_valid held: starts must be F+1 cycles apart.
        wait_idle();
        tx_data = 8'h3C; tx_valid = 1'b1;
        t0 = -1; t1 = -1; acc = 0; guard = 0; prev_busy = busy;
        while (!(acc >= 2 && t1 >= 0) && guard < 3 * F) begin
            cycle();
            guard++;
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                chk("b2b_start_level", dataout, 1'b0);
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
            end
            prev_busy = busy;
            if (m_accept) begin
                acc++;
                $display("b2b accept %0d data=%02h cycle=%0d", acc, tx_data, cyc);
                if (acc == 1) tx_data = 8'hC3;
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_spacing", t1 - t0, F + 1);
        wait_idle();
        cycle();

        // Reset pulse during data bit 5 of 0xFF, then a clean 0x01.
        tx_data = 8'hFF; tx_valid = 1'b1;
        cycle();
        tx_valid = 1'b0;
        repeat (6 * CPB + 1) cycle();
        chk("ff_bit5_level", dataout, 1'b1);
        rst = 1'b0;
        cycle();
        chk("rst_mid_dataout", dataout, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        rst = 1'b1;
        cycle();
        $display("mid-frame reset done");
        run_vec('{8'h01, -1, 0, 10'b1000000010, 1'b1});

        // Randomized traffic with enable stalls and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            tx_valid = ($urandom_range(0, 2) != 0);
            en       = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 299) != 0);
            tx_data  = DW'($urandom);
            cycle();
            if (m_accept) $display("random accept data=%02h cycle=%0d", tx_data, cyc);
        end
        rst = 1'b1; en = 1'b1; tx_valid = 1'b0;
        wait_idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that serializes parallel words onto the single-bit line consumed by the `toplevel` receive path (`datain`). It is the sending end of that link. It sits in the test environments as a stimulus source and in the design as the egress serializer for order/market words. It accepts one word per valid/ready handshake and emits an idle-high, LSB-first frame: start bit, data, optional parity, stop bit.

## Interface
- `DATA_W`, 8: payload width in bits; must be ≥ 2.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥ 1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  clock enable; when low, all state, counters and `dataout` hold.
- `tx_data`  in  DATA_W  word to send; sampled only on an accepted handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word this cycle.
- `dataout`  out  1  serial line; idles at 1.
- `busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- `tx_ready` is combinational and equals `rst && en && (state == IDLE)`.
- Accept occurs when `tx_valid && tx_ready` at a rising edge. On accept:
  - `tx_data` is latched into the shift register.
  - The parity accumulator is loaded.
  - The FSM moves to START.
- START: `dataout` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `dataout` = shift_reg[0] (LSB first).
  - The register shifts right once per bit.
  - After DATA_W bits, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: `dataout` = even parity, i.e. the XOR of all DATA_W bits. Lasts one bit, then go to STOP.
- STOP: `dataout` = 1 for one bit, then return to IDLE.
- Bit timer counts from 0 to CLKS_PER_BIT-1 and produces `bit_done` on terminal count.
  - Width is `$clog2(CLKS_PER_BIT)`, with a minimum of 1.
  - It resets to 0 on every state change.
- Bit counter width is `$clog2(DATA_W)`. The DATA state exits when the counter equals DATA_W-1 and `bit_done` is high.
- When `en` is low:
  - FSM, bit timer, bit counter and shift register hold.
  - `dataout` holds its value.
  - `tx_ready` = 0.
  - The frame resumes exactly where it stopped when `en` returns high.
- `tx_valid` deasserting while `tx_ready` = 0 has no effect. Words are never dropped or duplicated.

## Timing
- Reset values: `dataout` = 1, `busy` = 0, `tx_ready` = 0 while `rst` = 0, state IDLE, all counters 0.
- `dataout` and `busy` are registered.
- Accept at edge N:
  - `dataout` = 0 and `busy` = 1 from cycle N+1.
  - Start bit occupies cycles N+1 … N+CLKS_PER_BIT.
- Frame length is F = (2 + DATA_W [+1 parity]) × CLKS_PER_BIT cycles. With defaults: 40 cycles without parity, 44 with parity.
- `busy` drops, and `tx_ready` rises (if `en` = 1), in cycle N+F+1.
- Back-to-back frames therefore start every F+1 cycles. The extra cycle is one idle-high cycle.
- Reset mid-frame: at the first edge with `rst` = 0:
  - Return to IDLE and set `dataout` = 1.
  - The in-flight word is discarded, not resent.
- If `rst` = 0 and `en` = 0 at the same edge, reset wins.
- CLKS_PER_BIT = 1: one bit per cycle. Timer is a single-bit register held at 0, so `bit_done` is always 1.

## Configuration
- `SERIAL_FRAME_TX_PARITY_EN` defined:
  - The PARITY state and parity register are compiled in.
  - Frame = start, DATA_W data bits, even parity bit, stop.
- Not defined:
  - No parity logic is present.
  - DATA goes straight to STOP.
  - Frame = start, DATA_W data bits, stop.

## Structure
- Package `serial_frame_pkg` holds:
  - `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Constants `LINE_IDLE` = 1'b1, `START_LEVEL` = 1'b0, `STOP_LEVEL` = 1'b1.
  - Shared by the matching receiver and its testbenches.
- Sub-module `frame_bit_timer`:
  - Parameter: CLKS_PER_BIT.
  - Inputs: `clk`, `rst`, `en`, `clear`. Output: `bit_done`.
  - Instantiated once.
- Top-level `serial_frame_tx` holds the FSM, shift register, bit counter and optional parity.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles, with `tx_valid` = 1 → `dataout` = 1, `busy` = 0, `tx_ready` = 0 throughout. `tx_ready` = 1 the first cycle after `rst` = 1 with `en` = 1.
- Single frame, defaults, 0xA5, no parity → line reads 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles. `busy` high for exactly 40 cycles.
- Parity build, 0xA5 and 0x07 → parity bits 0 and 1 respectively; frame is 44 cycles each.
- Back-to-back 0x3C then 0xC3 with `tx_valid` held high → second start bit begins exactly 41 cycles after the first. Both words are received intact.
- `en` dropped for 7 cycles in the middle of data bit 3 → `dataout` frozen during the stall. Frame completes 7 cycles late with identical bit sequence.
- `rst` pulsed low during data bit 5 of 0xFF → `dataout` = 1 and `busy` = 0 the next cycle. The next accepted word 0x01 is sent cleanly from START.
